// File: rtl/perm_lookup_arbiter_pkg.sv
// Shared types and helpers for the permission lookup arbiter.
// Package perm_pkg: perm width, perm struct, round-robin pointer step.
package perm_pkg;

  localparam int PERM_W = 3;

  typedef struct packed {
    logic r;
    logic w;
    logic x;
  } perm_t;

  // Pointer step with wrap from n-1 back to 0
  function automatic int unsigned rr_next(
    input int unsigned ptr,
    input int unsigned n
  );
    return (ptr + 1 >= n) ? 32'd0 : ptr + 1;
  endfunction

endpackage

// File: rtl/perm_lookup_arbiter_if.sv
// Request/lookup/response bundle for perm_lookup_arbiter.
// io_grant_cnt exists only when PERM_ARB_CNT_EN is defined.
interface perm_lookup_arbiter_if
  import perm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 32
) ();

  logic [NREQ-1:0]        io_req_valid;
  logic [NREQ-1:0]        io_req_ready;
  logic [NREQ*AW-1:0]     io_req_addr;
  logic                   io_stall;
  logic                   io_flush;
  logic                   io_lk_valid;
  logic [AW-1:0]          io_lk_addr;
  logic [PERM_W-1:0]      io_lk_perm;
  logic [NREQ-1:0]        io_resp_valid;
  logic [NREQ*PERM_W-1:0] io_resp_perm;
`ifdef PERM_ARB_CNT_EN
  logic [NREQ*16-1:0]     io_grant_cnt;
`endif

  modport master (
    output io_req_valid, io_req_addr, io_stall, io_flush, io_lk_perm,
    input  io_req_ready, io_lk_valid, io_lk_addr, io_resp_valid,
`ifdef PERM_ARB_CNT_EN
    input  io_grant_cnt,
`endif
    input  io_resp_perm
  );

  modport slave (
    input  io_req_valid, io_req_addr, io_stall, io_flush, io_lk_perm,
    output io_req_ready, io_lk_valid, io_lk_addr, io_resp_valid,
`ifdef PERM_ARB_CNT_EN
    output io_grant_cnt,
`endif
    output io_resp_perm
  );

endinterface

// File: rtl/perm_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Grants the first request at or after ptr, modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  // Scan requesters starting at ptr, keep the first hit
  always_comb begin
    int j;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (en && !any && req[j]) begin
        gnt[j] = 1'b1;
        gnt_id = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/perm_lookup_arbiter.sv
// Round-robin sharing of one fixed-latency perm lookup port.
// Optional PERM_ARB_CNT_EN adds saturating per-requester grant counters.
module perm_lookup_arbiter
  import perm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int LAT  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  perm_lookup_arbiter_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]          ptr;
  logic [NREQ-1:0]        gnt;
  logic [IW-1:0]          gnt_id;
  logic                   any;
  logic                   en;
  logic [LAT-1:0]         tag_v;
  logic [IW-1:0]          tag_id [LAT];
  logic                   cap;
  perm_t                  lk_perm;
  logic [NREQ-1:0]        resp_valid_q;
  logic [NREQ*PERM_W-1:0] resp_perm_q;

  assign en = !reset && !bus.io_stall && !bus.io_flush;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req    (bus.io_req_valid),
    .ptr    (ptr),
    .en     (en),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign bus.io_req_ready = gnt;
  assign bus.io_lk_valid  = any;
  assign bus.io_lk_addr   = bus.io_req_addr[int'(gnt_id)*AW +: AW];

  // Advance pointer past the granted requester
  always_ff @(posedge clock) begin
    if (reset) ptr <= '0;
    else if (any) ptr <= IW'(rr_next(32'(gnt_id), NREQ));
  end

  // Tag valid pipe; flush kills every in-flight lookup
  always_ff @(posedge clock) begin
    if (reset || bus.io_flush) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= any;
      for (int i = 1; i < LAT; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  // Tag id pipe; meaningful only where the matching valid is set
  always_ff @(posedge clock) begin
    tag_id[0] <= gnt_id;
    for (int i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
  end

  assign cap     = tag_v[LAT-1] && !bus.io_flush;
  assign lk_perm = bus.io_lk_perm;

  // Capture returning perm into the owner's slice, strobe one cycle later
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= '0;
      resp_perm_q  <= '0;
    end else begin
      resp_valid_q <= '0;
      if (cap) begin
        resp_valid_q[tag_id[LAT-1]] <= 1'b1;
        resp_perm_q[int'(tag_id[LAT-1])*PERM_W +: PERM_W] <= lk_perm;
      end
    end
  end

  assign bus.io_resp_valid = resp_valid_q;
  assign bus.io_resp_perm  = resp_perm_q;

`ifdef PERM_ARB_CNT_EN
  logic [15:0] cnt [NREQ];

  // Saturating grant counters, one per requester
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (gnt[i] && bus.io_req_valid[i] && cnt[i] != 16'hFFFF)
          cnt[i] <= cnt[i] + 16'd1;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    assign bus.io_grant_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_perm_lookup_arbiter.sv
// Randomized + directed bench for perm_lookup_arbiter.
// Reference model: pointer scan plus a queue of due responses.
module tb_perm_lookup_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int LAT  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  perm_lookup_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

  perm_lookup_arbiter #(.NREQ(NREQ), .AW(AW), .LAT(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int due;
    int id;
  } pend_t;

  int              checks = 0;
  int              errors = 0;
  int              cyc    = 0;
  int              mptr   = 0;
  bit              known  = 1'b0;
  logic [NREQ-1:0] erv    = '0;
  logic [NREQ*3-1:0] eperm = '0;
  pend_t           q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input bit st,
                      input bit fl, input bit rs,
                      input logic [2:0] pm, output int g);
    logic [AW-1:0]   a [NREQ];
    logic [NREQ-1:0] nrv;
    pend_t           nq[$];
    bus.io_req_valid = v;
    bus.io_stall     = st;
    bus.io_flush     = fl;
    bus.io_lk_perm   = pm;
    reset            = rs;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = $urandom;
      bus.io_req_addr[i*AW +: AW] = a[i];
    end
    g = -1;
    if (!rs && !st && !fl)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
    @(negedge clock);
    chk("ready", 64'(bus.io_req_ready), g < 0 ? 64'd0 : 64'd1 << g);
    chk("lk_valid", 64'(bus.io_lk_valid), 64'(g >= 0));
    if (g >= 0) chk("lk_addr", 64'(bus.io_lk_addr), 64'(a[g]));
    if (known) begin
      chk("resp_valid", 64'(bus.io_resp_valid), 64'(erv));
      chk("resp_perm", 64'(bus.io_resp_perm), 64'(eperm));
    end
    @(posedge clock);
    if (rs) begin
      q.delete();
      mptr  = 0;
      erv   = '0;
      eperm = '0;
      known = 1'b1;
    end else begin
      nrv = '0;
      foreach (q[i]) begin
        if (q[i].due == cyc) begin
          if (!fl) begin
            eperm[q[i].id*3 +: 3] = pm;
            nrv[q[i].id] = 1'b1;
          end
        end else begin
          nq.push_back(q[i]);
        end
      end
      q = nq;
      if (fl) q.delete();
      if (g >= 0) begin
        q.push_back('{due: cyc + LAT, id: g});
        mptr = (g + 1) % NREQ;
      end
      erv = nrv;
    end
    cyc++;
    #1;
  endtask

  initial begin
    int g;
    int pre;
    bus.io_req_valid = '0;
    bus.io_req_addr  = '0;
    bus.io_stall     = 1'b0;
    bus.io_flush     = 1'b0;
    bus.io_lk_perm   = '0;

    for (int i = 0; i < 3; i++) step('1, 0, 0, 1, 3'b000, g);
    chk("rst_resp_perm", 64'(bus.io_resp_perm), 64'd0);
    chk("rst_resp_valid", 64'(bus.io_resp_valid), 64'd0);

    for (int i = 0; i < 8; i++) begin
      step('1, 0, 0, 0, 3'b101, g);
      chk("rr_order", 64'(g), 64'(i % 4));
    end
    for (int i = 0; i < LAT + 2; i++) step('0, 0, 0, 0, 3'b101, g);

    step(4'b0100, 0, 0, 0, 3'b011, g);
    chk("t3_g1", 64'(g), 64'd2);
    step(4'b0100, 0, 0, 0, 3'b011, g);
    chk("t3_wrap", 64'(g), 64'd2);
    for (int i = 0; i < LAT; i++) step('0, 0, 0, 0, 3'b011, g);
    chk("t3_rv", 64'(bus.io_resp_valid), 64'b0100);
    chk("t3_perm", 64'(bus.io_resp_perm[8:6]), 64'b011);
    chk("t3_others", 64'({bus.io_resp_perm[11:9], bus.io_resp_perm[5:0]}),
        64'o555);
    step('0, 0, 0, 0, 3'b011, g);

    step('1, 0, 0, 0, 3'b110, g);
    chk("t4_g0", 64'(g), 64'd3);
    step('1, 0, 0, 0, 3'b110, g);
    pre = mptr;
    step('1, 0, 1, 0, 3'b110, g);
    chk("t4_flush_gnt", 64'(g + 1), 64'd0);
    for (int i = 0; i < LAT + 1; i++) begin
      step('0, 0, 0, 0, 3'b110, g);
      chk("t4_no_resp", 64'(bus.io_resp_valid), 64'd0);
    end
    step('1, 0, 0, 0, 3'b110, g);
    chk("t4_ptr", 64'(g), 64'(pre));
    for (int i = 0; i < LAT + 1; i++) step('0, 0, 0, 0, 3'b001, g);

    pre = mptr;
    for (int i = 0; i < 5; i++) begin
      step('1, 1, 0, 0, 3'b010, g);
      chk("t5_stall", 64'(g + 1), 64'd0);
    end
    step('1, 1, 1, 0, 3'b010, g);
    step('1, 0, 0, 0, 3'b010, g);
    chk("t5_resume", 64'(g), 64'(pre));

    step('1, 0, 0, 0, 3'b111, g);
    step('1, 0, 0, 1, 3'b111, g);
    for (int i = 0; i < LAT + 1; i++) begin
      step('0, 0, 0, 0, 3'b111, g);
      chk("rst_mid_no_resp", 64'(bus.io_resp_valid), 64'd0);
    end

    for (int i = 0; i < 600; i++)
      step(NREQ'($urandom), $urandom_range(9) == 0,
           $urandom_range(19) == 0, $urandom_range(99) == 0,
           3'($urandom), g);
    for (int i = 0; i < LAT + 2; i++) step('0, 0, 0, 0, 3'b000, g);

`ifdef PERM_ARB_CNT_EN
    step('0, 0, 0, 1, 3'b000, g);
    chk("cnt_rst", 64'(bus.io_grant_cnt), 64'd0);
    for (int i = 0; i < 70000; i++) step(4'b0001, 0, 0, 0, 3'b100, g);
    chk("cnt_sat", 64'(bus.io_grant_cnt[15:0]), 64'hFFFF);
    chk("cnt_other", 64'(bus.io_grant_cnt[63:16]), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
